// File: rtl/key_loader_serial.sv
// ============================================================================
// Module   : key_loader_serial
// Brief    : Serial even-parity key loader feeding the keyinput bus of an
//            RLL-locked core. Optional lockout: KEY_LOADER_LOCKOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_loader_serial #(
    parameter int                   KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0] KEY_SAFE  = '0,
    parameter int                   MAX_FAIL  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 sdi,
    input  logic                 sdi_valid,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_loaded,
    output logic                 load_err,
    output logic                 busy
);

    localparam int                 c_cnt_w    = (KEY_WIDTH > 2) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(KEY_WIDTH - 1);

    if (KEY_WIDTH < 2 || MAX_FAIL < 1) begin : g_bad_cfg
        $error("key_loader_serial: KEY_WIDTH must be >= 2 and MAX_FAIL >= 1");
    end

`ifdef KEY_LOADER_LOCKOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOADED = 3'd4,
        ST_ERROR  = 3'd5,
        ST_LOCKED = 3'd6
    } state_t;

    localparam int                  c_fail_w    = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
    localparam logic [c_fail_w-1:0] c_fail_last = c_fail_w'(MAX_FAIL - 1);

    logic [c_fail_w-1:0] r_fail_cnt;
    logic                w_lock;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_LOADED = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;
`endif

    state_t               r_state;
    state_t               w_next;
    logic [KEY_WIDTH-1:0] r_shreg;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_par;
    logic [KEY_WIDTH-1:0] r_key;
    logic                 r_loaded;
    logic                 r_err;
    logic                 w_xfer;
    logic                 w_restart;
    logic                 w_pass;

    assign sdi_ready = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign busy      = sdi_ready || (r_state == ST_CHECK);
    assign w_xfer    = sdi_valid && sdi_ready;
    assign w_pass    = ((^r_shreg) == r_par);

    // A locked loader ignores load_start; otherwise it always restarts the frame.
`ifdef KEY_LOADER_LOCKOUT_EN
    assign w_restart = load_start && (r_state != ST_LOCKED);
    assign w_lock    = (r_fail_cnt == c_fail_last);
`else
    assign w_restart = load_start;
`endif

    assign key_out    = r_key;
    assign key_loaded = r_loaded;
    assign load_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_restart) begin
            w_next = ST_SHIFT;
        end else begin
            case (r_state)
                ST_SHIFT:  if (w_xfer && (r_cnt == c_cnt_last)) w_next = ST_PARITY;
                ST_PARITY: if (w_xfer) w_next = ST_CHECK;
                ST_CHECK: begin
                    if (w_pass) begin
                        w_next = ST_LOADED;
                    end else begin
`ifdef KEY_LOADER_LOCKOUT_EN
                        w_next = w_lock ? ST_LOCKED : ST_ERROR;
`else
                        w_next = ST_ERROR;
`endif
                    end
                end
                default:   w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_key    <= KEY_SAFE;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_restart) begin
            // Restart wins over any coincident transfer: that bit is dropped.
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_key    <= KEY_SAFE;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_xfer) begin
                        r_shreg[r_cnt] <= sdi;
                        if (r_cnt != c_cnt_last) r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_PARITY: if (w_xfer) r_par <= sdi;
                ST_CHECK: begin
                    if (w_pass) begin
                        r_key    <= r_shreg;
                        r_loaded <= 1'b1;
                    end else begin
                        r_key    <= KEY_SAFE;
                        r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KEY_LOADER_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail_cnt <= '0;
        end else if (!w_restart && (r_state == ST_CHECK)) begin
            if (w_pass) r_fail_cnt <= '0;
            else        r_fail_cnt <= r_fail_cnt + c_fail_w'(1);
        end
    end
`endif

endmodule

`default_nettype wire
